wb_snoop_arbiter_mc: RTL and testbench

//  N-master -> 1-slave Wishbone arbiter with cache-coherence snooping for the

---
 rtl/wb_snoop_pkg.sv | 27 ++
 rtl/wb_snoop_rr_arbiter.sv | 61 ++++++
 rtl/wb_snoop_arbiter_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_snoop_arbiter_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_snoop_pkg.sv
// Shared types and constants for the snooping Wishbone arbiter.
// The optional write-invalidate feature is WB_SNOOP_WRITE_INV_EN.
package wb_snoop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSnoopRd,
    StSnoopInv,
    StSnoopRsp,
    StMem
  } snoop_state_e;

  localparam logic [1:0] SNOOP_TYPE_IDLE = 2'b00;
  localparam logic [1:0] SNOOP_TYPE_READ = 2'b01;
  localparam logic [1:0] SNOOP_TYPE_INV  = 2'b10;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_snoop_rr_arbiter.sv
// Round-robin arbiter: searches from pointer+1, holds the grant until release,
// then moves the pointer to the released index.
module wb_snoop_rr_arbiter
  import wb_snoop_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            arb_en_i,
  input  logic            rel_i,
  output logic [N-1:0]    gnt_oh_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            win_vld_o,
  output logic [IdxW-1:0] win_idx_o
);

  logic [IdxW-1:0] ptr_q, gnt_idx_q, win_idx, cand;
  logic            gnt_vld_q, win_vld;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else if (rel_i) begin
      ptr_q     <= gnt_idx_q;
      gnt_vld_q <= 1'b0;
    end else if (arb_en_i && win_vld) begin
      gnt_idx_q <= win_idx;
      gnt_vld_q <= 1'b1;
    end
  end

  always_comb begin
    gnt_oh_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_oh_o[i] = gnt_vld_q && (gnt_idx_q == IdxW'(i));
    end
  end

  assign gnt_idx_o = gnt_idx_q;
  assign win_vld_o = win_vld;
  assign win_idx_o = win_idx;

endmodule

// File: rtl/wb_snoop_arbiter_mc.sv
// N-master to 1-slave Wishbone arbiter with read snooping on the data buses.
// Define WB_SNOOP_WRITE_INV_EN to snoop-invalidate on data-bus writes.
module wb_snoop_arbiter_mc
  import wb_snoop_pkg::*;
#(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned num_masters = 4,
  parameter int unsigned num_dbus    = 2,
  parameter int unsigned snoop_tmo   = 15
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [num_masters*aw-1:0] wbm_adr_i,
  input  logic [num_masters*dw-1:0] wbm_dat_i,
  input  logic [num_masters*4-1:0]  wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [num_masters*3-1:0]  wbm_cti_i,
  input  logic [num_masters*2-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0] wbm_dat_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [aw-1:0]             snoop_adr_o,
  output logic [1:0]                snoop_type_o,
  output logic [num_dbus-1:0]       snoop_req_o,
  input  logic [num_dbus-1:0]       snoop_ack_i,
  input  logic [num_dbus-1:0]       snoop_hit_i,
  input  logic [num_dbus*dw-1:0]    snoop_dat_i
);

  localparam int unsigned IdxW = (num_masters > 1) ? clog2(num_masters) : 1;
  localparam int unsigned CntW = clog2(snoop_tmo + 1);

  logic [aw-1:0] m_adr [num_masters];
  logic [dw-1:0] m_dat [num_masters];
  logic [3:0]    m_sel [num_masters];
  logic [2:0]    m_cti [num_masters];
  logic [1:0]    m_bte [num_masters];
  logic [dw-1:0] s_dat [num_dbus];

  for (genvar i = 0; i < num_masters; i++) begin : g_unpack_m
    assign m_adr[i] = wbm_adr_i[i*aw +: aw];
    assign m_dat[i] = wbm_dat_i[i*dw +: dw];
    assign m_sel[i] = wbm_sel_i[i*4 +: 4];
    assign m_cti[i] = wbm_cti_i[i*3 +: 3];
    assign m_bte[i] = wbm_bte_i[i*2 +: 2];
  end

  for (genvar i = 0; i < num_dbus; i++) begin : g_unpack_s
    assign s_dat[i] = snoop_dat_i[i*dw +: dw];
  end

  snoop_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [aw-1:0]        snoop_adr_q, snoop_adr_d;
  logic [dw-1:0]        snoop_dat_q, snoop_dat_d;
  logic [num_masters-1:0] gnt_oh;
  logic [IdxW-1:0]      gnt_idx, win_idx;
  logic                 win_vld, win_dbus, arb_en, rel, cyc_g, tmo;
  logic [num_dbus-1:0]  req_mask, ack_eff, hit_v;
  logic [dw-1:0]        hit_dat;

  assign arb_en = (state_q == StIdle);
  assign rel    = (state_q != StIdle) && (state_d == StIdle);

  wb_snoop_rr_arbiter #(
    .N    (num_masters),
    .IdxW (IdxW)
  ) u_arb (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_i     (wbm_cyc_i),
    .arb_en_i  (arb_en),
    .rel_i     (rel),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .win_vld_o (win_vld),
    .win_idx_o (win_idx)
  );

  assign cyc_g    = wbm_cyc_i[gnt_idx];
  assign win_dbus = (32'(win_idx) < num_dbus);
  // The requester never snoops itself: treat its lane as an acked miss.
  assign req_mask = gnt_oh[num_dbus-1:0];
  assign ack_eff  = snoop_ack_i | req_mask;
  assign hit_v    = snoop_ack_i & snoop_hit_i & ~req_mask;
  assign tmo      = (cnt_q == CntW'(snoop_tmo - 1));

  always_comb begin
    hit_dat = '0;
    for (int i = num_dbus - 1; i >= 0; i--) begin
      if (hit_v[i]) hit_dat = s_dat[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CntW'(snoop_tmo)) ? cnt_q : cnt_q + 1'b1;
    snoop_adr_d = snoop_adr_q;
    snoop_dat_d = snoop_dat_q;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          snoop_adr_d = m_adr[win_idx];
          cnt_d       = '0;
          if (win_dbus && !wbm_we_i[win_idx] &&
              (m_cti[win_idx] == CTI_CLASSIC || m_cti[win_idx] == CTI_END)) begin
            state_d = StSnoopRd;
`ifdef WB_SNOOP_WRITE_INV_EN
          end else if (win_dbus && wbm_we_i[win_idx]) begin
            state_d = StSnoopInv;
`endif
          end else begin
            state_d = StMem;
          end
        end
      end
      StSnoopRd: begin
        snoop_adr_d = m_adr[gnt_idx];
        if (!cyc_g) begin
          state_d = StIdle;
        end else if (|hit_v) begin
          state_d     = StSnoopRsp;
          snoop_dat_d = hit_dat;
        end else if ((&ack_eff) || tmo) begin
          state_d = StMem;
        end
      end
      StSnoopInv: begin
        snoop_adr_d = m_adr[gnt_idx];
        if (!cyc_g) begin
          state_d = StIdle;
        end else if ((&ack_eff) || tmo) begin
          state_d = StMem;
        end
      end
      StSnoopRsp: begin
        if (cyc_g && m_cti[gnt_idx] == CTI_END) begin
          state_d = StSnoopRd;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StMem: begin
        if (!cyc_g) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      snoop_adr_q <= '0;
      snoop_dat_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snoop_adr_q <= snoop_adr_d;
      snoop_dat_q <= snoop_dat_d;
    end
  end

  always_comb begin
    wbm_dat_o    = '0;
    wbm_ack_o    = '0;
    wbm_err_o    = '0;
    wbm_rty_o    = '0;
    wbs_adr_o    = '0;
    wbs_dat_o    = '0;
    wbs_sel_o    = '0;
    wbs_we_o     = 1'b0;
    wbs_cyc_o    = 1'b0;
    wbs_stb_o    = 1'b0;
    wbs_cti_o    = '0;
    wbs_bte_o    = '0;
    snoop_req_o  = '0;
    snoop_type_o = SNOOP_TYPE_IDLE;
    case (state_q)
      StSnoopRd: begin
        snoop_type_o = SNOOP_TYPE_READ;
        snoop_req_o  = ~req_mask;
      end
      StSnoopInv: begin
        snoop_type_o = SNOOP_TYPE_INV;
        snoop_req_o  = ~req_mask;
      end
      StSnoopRsp: begin
        if (cyc_g) wbm_ack_o = gnt_oh;
        wbm_dat_o = {num_masters{snoop_dat_q}};
      end
      StMem: begin
        wbs_adr_o = m_adr[gnt_idx];
        wbs_dat_o = m_dat[gnt_idx];
        wbs_sel_o = m_sel[gnt_idx];
        wbs_we_o  = wbm_we_i[gnt_idx];
        wbs_cyc_o = cyc_g;
        wbs_stb_o = wbm_stb_i[gnt_idx];
        wbs_cti_o = m_cti[gnt_idx];
        wbs_bte_o = m_bte[gnt_idx];
        wbm_dat_o = {num_masters{wbs_dat_i}};
        wbm_ack_o = gnt_oh & {num_masters{wbs_ack_i}};
        wbm_err_o = gnt_oh & {num_masters{wbs_err_i}};
        wbm_rty_o = gnt_oh & {num_masters{wbs_rty_i}};
      end
      default: ;
    endcase
  end

  assign snoop_adr_o = snoop_adr_q;

endmodule

// File: tb/tb_wb_snoop_arbiter_mc.sv
// Directed bench for wb_snoop_arbiter_mc; expectations follow
// WB_SNOOP_WRITE_INV_EN when it is defined.
module tb_wb_snoop_arbiter_mc;

  localparam int DW = 32, AW = 32, NM = 4, ND = 2, TMO = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM*AW-1:0]  wbm_adr_i = '0;
  logic [NM*DW-1:0]  wbm_dat_i = '0;
  logic [NM*4-1:0]   wbm_sel_i = '0;
  logic [NM-1:0]     wbm_we_i = '0, wbm_cyc_i = '0, wbm_stb_i = '0;
  logic [NM*3-1:0]   wbm_cti_i = '0;
  logic [NM*2-1:0]   wbm_bte_i = '0;
  logic [NM*DW-1:0]  wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i = '0;
  logic              wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;
  logic [AW-1:0]     snoop_adr_o;
  logic [1:0]        snoop_type_o;
  logic [ND-1:0]     snoop_req_o;
  logic [ND-1:0]     snoop_ack_i = '0, snoop_hit_i = '0;
  logic [ND*DW-1:0]  snoop_dat_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_snoop_arbiter_mc #(
    .dw(DW), .aw(AW), .num_masters(NM), .num_dbus(ND), .snoop_tmo(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .snoop_adr_o(snoop_adr_o), .snoop_type_o(snoop_type_o), .snoop_req_o(snoop_req_o),
    .snoop_ack_i(snoop_ack_i), .snoop_hit_i(snoop_hit_i), .snoop_dat_i(snoop_dat_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic [31:0] adr, input logic we,
                       input logic [2:0] cti, input logic cyc);
    wbm_adr_i[i*AW +: AW] = adr;
    wbm_we_i[i]           = we;
    wbm_cti_i[i*3 +: 3]   = cti;
    wbm_cyc_i[i]          = cyc;
    wbm_stb_i[i]          = cyc;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ack"}, 64'(wbm_ack_o), 64'h0);
    check_eq({tag, "_wcyc"}, 64'(wbs_cyc_o), 64'h0);
    check_eq({tag, "_sreq"}, 64'(snoop_req_o), 64'h0);
    check_eq({tag, "_stype"}, 64'(snoop_type_o), 64'h0);
    check_eq({tag, "_sadr"}, 64'(snoop_adr_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got_mem;
    int order [5];
    order = '{1, 2, 3, 0, 1};

    repeat (2) tick();
    check_idle("rst");
    rst = 1'b0;

    // Reset while snooping
    tick();
    set_m(0, 32'h180, 1'b0, 3'b000, 1'b1);
    tick();
    check_eq("t1_pre_type", 64'(snoop_type_o), 64'h1);
    check_eq("t1_pre_adr", 64'(snoop_adr_o), 64'h180);
    #2 rst = 1'b1;
    tick();
    check_idle("t1_rst");
    rst = 1'b0;
    set_m(0, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // Snoop hit from dbus1 served cache-to-cache
    snoop_ack_i = 2'b10;
    snoop_hit_i = 2'b10;
    snoop_dat_i = {32'hDEADBEEF, 32'h0000BAD0};
    set_m(0, 32'h100, 1'b0, 3'b000, 1'b1);
    tick();
    check_eq("t2_type", 64'(snoop_type_o), 64'h1);
    check_eq("t2_req", 64'(snoop_req_o), 64'h2);
    check_eq("t2_adr", 64'(snoop_adr_o), 64'h100);
    check_eq("t2_wcyc0", 64'(wbs_cyc_o), 64'h0);
    tick();
    check_eq("t2_ack", 64'(wbm_ack_o), 64'h1);
    check_eq("t2_dat", 64'(wbm_dat_o[31:0]), 64'hDEADBEEF);
    check_eq("t2_wcyc1", 64'(wbs_cyc_o), 64'h0);
    set_m(0, 32'h0, 1'b0, 3'b000, 1'b0);
    snoop_ack_i = '0;
    snoop_hit_i = '0;
    tick();
    check_eq("t2_ack_end", 64'(wbm_ack_o), 64'h0);
    check_eq("t2_type_end", 64'(snoop_type_o), 64'h0);

    // Snoop miss falls through to memory
    snoop_ack_i = 2'b01;
    wbs_dat_i   = 32'h12345678;
    wbs_ack_i   = 1'b1;
    set_m(1, 32'h200, 1'b0, 3'b000, 1'b1);
    tick();
    check_eq("t3_req", 64'(snoop_req_o), 64'h1);
    check_eq("t3_wcyc0", 64'(wbs_cyc_o), 64'h0);
    check_eq("t3_noack", 64'(wbm_ack_o), 64'h0);
    tick();
    check_eq("t3_wcyc1", 64'(wbs_cyc_o), 64'h1);
    check_eq("t3_wadr", 64'(wbs_adr_o), 64'h200);
    check_eq("t3_ack", 64'(wbm_ack_o), 64'h2);
    check_eq("t3_dat", 64'(wbm_dat_o[63:32]), 64'h12345678);
    set_m(1, 32'h0, 1'b0, 3'b000, 1'b0);
    wbs_ack_i   = 1'b0;
    snoop_ack_i = '0;
    tick();
    check_eq("t3_wcyc_end", 64'(wbs_cyc_o), 64'h0);

    // Snoop timeout
    set_m(1, 32'h240, 1'b0, 3'b000, 1'b1);
    n       = 0;
    got_mem = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wbs_cyc_o) begin
        got_mem = 1'b1;
        break;
      end
      if (snoop_req_o != '0) n++;
    end
    check_eq("t4_mem", 64'(got_mem), 64'h1);
    check_eq("t4_cycles", 64'(n), 64'(TMO));
    check_eq("t4_wadr", 64'(wbs_adr_o), 64'h240);
    set_m(1, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // Round-robin with every master requesting bursts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NM; i++) set_m(i, 32'h1000 + 32'(16 * i), 1'b0, 3'b010, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t5_gnt%0d", k), 64'(wbs_adr_o), 64'(32'h1000 + 32'(16 * order[k])));
      set_m(order[k], 32'h1000 + 32'(16 * order[k]), 1'b0, 3'b010, 1'b0);
      tick();
      set_m(order[k], 32'h1000 + 32'(16 * order[k]), 1'b0, 3'b010, 1'b1);
    end
    for (int i = 0; i < NM; i++) set_m(i, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // Data-bus write
    snoop_ack_i = 2'b10;
    snoop_hit_i = 2'b10;
    set_m(0, 32'h300, 1'b1, 3'b000, 1'b1);
    tick();
`ifdef WB_SNOOP_WRITE_INV_EN
    check_eq("t6_type", 64'(snoop_type_o), 64'h2);
    check_eq("t6_req", 64'(snoop_req_o), 64'h2);
    check_eq("t6_wcyc0", 64'(wbs_cyc_o), 64'h0);
    tick();
`else
    check_eq("t6_type", 64'(snoop_type_o), 64'h0);
    check_eq("t6_req", 64'(snoop_req_o), 64'h0);
`endif
    check_eq("t6_wcyc", 64'(wbs_cyc_o), 64'h1);
    check_eq("t6_wadr", 64'(wbs_adr_o), 64'h300);
    check_eq("t6_wwe", 64'(wbs_we_o), 64'h1);
    check_eq("t6_type_mem", 64'(snoop_type_o), 64'h0);
    set_m(0, 32'h0, 1'b0, 3'b000, 1'b0);
    snoop_ack_i = '0;
    snoop_hit_i = '0;
    tick();

    // Non-snooping master read goes straight to memory
    set_m(2, 32'h400, 1'b0, 3'b000, 1'b1);
    tick();
    check_eq("t7_wcyc", 64'(wbs_cyc_o), 64'h1);
    check_eq("t7_wadr", 64'(wbs_adr_o), 64'h400);
    check_eq("t7_type", 64'(snoop_type_o), 64'h0);
    set_m(2, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();
    check_eq("t7_wcyc_end", 64'(wbs_cyc_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
